fifo_drain: RTL and testbench

//   Downstream consumer for fifo: batches fifo entries into bursts on a valid/ready stream.

---
 rtl/fifo_drain.sv | 163 ++++++++++++++++
 tb/tb_fifo_drain.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: drains an upstream fifo in bursts onto a valid/ready stream.
// Waits in IDLE until THRESHOLD entries are present, then pops up to MAXBURST
// entries through a 1-entry registered output stage; o_last marks the final word.
// Optional macro FIFO_DRAIN_TIMEOUT_EN: forces a partial burst after TIMEOUT
// idle cycles with a sub-threshold, non-empty fifo.
module fifo_drain #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int THRESHOLD = 4,
    parameter int MAXBURST  = 4,
    parameter int TIMEOUT   = 15,
    localparam int NW       = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_flush,
    input  logic             i_empty,
    input  logic [NW-1:0]    i_nEntries,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [NW-1:0] THRESH_N = NW'(THRESHOLD);
    localparam logic [NW-1:0] ONE_N    = NW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);

    // Elaboration-time guard against parameter values the logic cannot honour.
    if (THRESHOLD < 1 || THRESHOLD > DEPTH || MAXBURST < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_drain: illegal parameter value");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic slot;
    logic pop;
    logic accept;
    logic pop_last;
    logic start;

    // Output stage can take a new word when it is empty or being drained this cycle.
    assign slot     = !valid_q || i_ready;
    assign pop      = i_cg && !i_flush && (state_q == DRAIN) && !i_empty && slot;
    assign accept   = valid_q && i_ready;
    // Last word of a burst: burst length reached, or this pop empties the fifo.
    assign pop_last = (count_q == LAST_CNT) || (i_nEntries == ONE_N);

`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_N = TW'(TIMEOUT);

    logic [TW-1:0] tcnt_q, tcnt_d;

    assign start = (i_nEntries >= THRESH_N) || (tcnt_q == TIMEOUT_N);

    // Idle timeout counter: runs only with a non-empty sub-threshold fifo in IDLE.
    always_comb begin
        tcnt_d = tcnt_q;
        if (i_cg) begin
            if (i_flush || state_q == DRAIN || i_empty) begin
                tcnt_d = '0;
            end else if (start) begin
                tcnt_d = '0;
            end else if (i_nEntries < THRESH_N && tcnt_q < TIMEOUT_N) begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign start = (i_nEntries >= THRESH_N);
`endif

    // Next-state, burst counter and output stage; flush overrides pop and accept.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (!i_cg) begin
            // gated: everything holds
        end else if (i_flush) begin
            state_d = IDLE;
            count_d = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            if (accept) begin
                valid_d = 1'b0;
            end
            if (pop) begin
                valid_d = 1'b1;
                data_d  = i_data;
                last_d  = pop_last;
                count_d = count_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = DRAIN;
                        count_d = '0;
                    end
                end
                DRAIN: begin
                    if (pop && pop_last) begin
                        state_d = IDLE;
                    end else if (i_empty) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output-stage registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_pop   = pop;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q == DRAIN);

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: randomized and directed bench for fifo_drain with a queue-based
// upstream fifo and a scoreboard of popped / accepted words.
`timescale 1ns/1ps
module tb_fifo_drain;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 8;
    localparam int THRESHOLD = 4;
    localparam int MAXBURST  = 4;
    localparam int TIMEOUT   = 15;
    localparam int NW        = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_cg = 1'b1;
    logic             i_flush = 1'b0;
    logic             i_empty = 1'b1;
    logic [NW-1:0]    i_nEntries = '0;
    logic [WIDTH-1:0] i_data = '0;
    logic             o_pop;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             i_ready = 1'b0;
    logic             o_busy;

    fifo_drain #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .THRESHOLD(THRESHOLD),
        .MAXBURST(MAXBURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_flush(i_flush),
        .i_empty(i_empty), .i_nEntries(i_nEntries), .i_data(i_data),
        .o_pop(o_pop), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
        .i_ready(i_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic [WIDTH-1:0] fq[$];       // upstream fifo contents
    logic [WIDTH-1:0] pushed[$];   // every word pushed in the current test
    beat_t            outq[$];     // popped words not yet accepted by the sink
    beat_t            acc_log[$];  // words accepted by the sink in the current test
    int               burst_n;     // pops so far in the current burst
    int               pops;
    int               total = 0;
    int               bad = 0;

    task automatic set_view();
        i_empty    = (fq.size() == 0);
        i_nEntries = NW'(fq.size());
        if (fq.size() != 0) i_data = fq[0];
        else                i_data = '0;
    endtask

    task automatic push_words(input int n);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < n; i++) begin
            if (fq.size() < DEPTH) begin
                w = WIDTH'($urandom);
                fq.push_back(w);
                pushed.push_back(w);
            end
        end
        set_view();
    endtask

    // One clock cycle: sample just before the edge, update the model just after it.
    task automatic tick();
        logic s_pop, s_acc, s_flush, s_last, allowed;
        logic [WIDTH-1:0] s_data;
        int s_size;
        beat_t b;
        set_view();
        #4;
        s_pop   = o_pop;
        s_acc   = o_valid && i_ready && i_cg && !i_flush && !i_rst;
        s_flush = i_cg && i_flush && !i_rst;
        s_data  = o_data;
        s_last  = o_last;
        s_size  = fq.size();
        allowed = i_cg && !i_flush && !i_rst && (s_size != 0) && (!o_valid || i_ready);
        total++;
        if (o_valid !== (outq.size() != 0)) begin
            bad++;
            $display("FAIL valid_track got=%b exp=%b", o_valid, outq.size() != 0);
        end
        total++;
        if (s_pop === 1'bx || (s_pop && !allowed)) begin
            bad++;
            $display("FAIL pop_illegal got=%b exp=0 cg=%b flush=%b size=%0d", s_pop, i_cg, i_flush, s_size);
        end
        @(posedge i_clk);
        #1;
        if (s_flush) begin
            outq.delete();
            burst_n = 0;
        end else begin
            if (s_acc && outq.size() != 0) begin
                b = outq.pop_front();
                acc_log.push_back(b);
                $display("beat data=%02h last=%b", s_data, s_last);
                total++;
                if (s_data !== b.data || s_last !== b.last) begin
                    bad++;
                    $display("FAIL accept_word got=%02h/%b exp=%02h/%b", s_data, s_last, b.data, b.last);
                end
            end
            if (s_pop && s_size != 0) begin
                b.data = fq.pop_front();
                b.last = (burst_n + 1 == MAXBURST) || (s_size == 1);
`ifndef FIFO_DRAIN_TIMEOUT_EN
                if (burst_n == 0) begin
                    total++;
                    if (s_size < THRESHOLD) begin
                        bad++;
                        $display("FAIL burst_start got=%0d entries exp>=%0d", s_size, THRESHOLD);
                    end
                end
`endif
                total++;
                if (o_valid !== 1'b1 || o_data !== b.data || o_last !== b.last) begin
                    bad++;
                    $display("FAIL pop_load got=%b/%02h/%b exp=1/%02h/%b", o_valid, o_data, o_last, b.data, b.last);
                end
                burst_n = b.last ? 0 : burst_n + 1;
                outq.push_back(b);
                pops++;
            end
        end
        set_view();
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_cg = 1'b1; i_flush = 1'b0; i_ready = 1'b0;
        fq.delete(); pushed.delete(); outq.delete(); acc_log.delete();
        burst_n = 0; pops = 0;
        set_view();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Compare the accepted log against pushed[first .. first+n-1] with o_last on the final one.
    task automatic check_burst(input string name, input int first, input int n);
        total++;
        if (acc_log.size() != n) begin
            bad++;
            $display("FAIL %s_count got=%0d exp=%0d", name, acc_log.size(), n);
        end
        for (int i = 0; i < acc_log.size() && i < n && first + i < pushed.size(); i++) begin
            total++;
            if (acc_log[i].data !== pushed[first + i] || acc_log[i].last !== (i == n - 1)) begin
                bad++;
                $display("FAIL %s_word%0d got=%02h/%b exp=%02h/%b", name, i, acc_log[i].data,
                         acc_log[i].last, pushed[first + i], i == n - 1);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_ready = 1'b1;
        push_words(6);
        repeat (2) @(posedge i_clk);
        #2;
        total++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_pop !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%b/%02h/%b/%b/%b exp=0/00/0/0/0", o_valid, o_data, o_last, o_busy, o_pop);
        end
        // reset asserted mid-burst clears outputs at once; leftover entries drain next burst
        do_reset();
        push_words(4);
        repeat (3) tick();
        #2;
        i_rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_pop !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%b exp=0/0/0", o_valid, o_busy, o_pop);
        end
        outq.delete(); acc_log.delete(); burst_n = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        push_words(1);
        i_ready = 1'b1;
        repeat (8) tick();
        check_burst("reset_leftover", 1, 4);
    endtask

    task automatic test_single_burst();
        do_reset();
        i_ready = 1'b1;
        push_words(4);
        repeat (8) tick();
        check_burst("burst4", 0, 4);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL burst4_busy got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_partial_wait();
        int pops_before;
        do_reset();
        i_ready = 1'b1;
        push_words(6);
        repeat (12) tick();
`ifndef FIFO_DRAIN_TIMEOUT_EN
        check_burst("six", 0, 4);
        pops_before = pops;
        repeat (20) tick();
        total++;
        if (pops != pops_before || fq.size() != 2 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL six_wait got=pops%0d/left%0d/busy%b exp=pops%0d/left2/busy0",
                     pops, fq.size(), o_busy, pops_before);
        end
`else
        pops_before = pops;
        repeat (24) tick();
        total++;
        if (acc_log.size() != 6 || pops_before != 4 || acc_log[3].last !== 1'b1 || acc_log[5].last !== 1'b1) begin
            bad++;
            $display("FAIL six_timeout got=acc%0d/pops%0d exp=acc6/pops4", acc_log.size(), pops_before);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        push_words(4);
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (o_valid !== 1'b1 || o_data !== pushed[0] || pops != 1) begin
                bad++;
                $display("FAIL hold%0d got=%b/%02h/pops%0d exp=1/%02h/pops1", k, o_valid, o_data, pops, pushed[0]);
            end
        end
        i_ready = 1'b1;
        repeat (8) tick();
        check_burst("backpressure", 0, 4);
    endtask

    task automatic test_flush();
        do_reset();
        push_words(6);
        repeat (3) tick();
        total++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL preflush got=%b/%b exp=1/1", o_valid, o_busy);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_pop !== 1'b0 || fq.size() != 5 || o_data !== pushed[0]) begin
            bad++;
            $display("FAIL flush got=%b/%b/%b/left%0d/%02h exp=0/0/0/left5/%02h",
                     o_valid, o_busy, o_pop, fq.size(), o_data, pushed[0]);
        end
        i_ready = 1'b1;
        repeat (10) tick();
        check_burst("after_flush", 1, 4);
    endtask

    task automatic test_clock_gate();
        do_reset();
        i_ready = 1'b1;
        push_words(4);
        repeat (3) tick();
        i_cg = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_valid !== 1'b1 || o_data !== pushed[1] || o_last !== 1'b0 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL gated%0d got=%b/%02h/%b/%b exp=1/%02h/0/1", k, o_valid, o_data, o_last, o_busy, pushed[1]);
            end
        end
        i_cg = 1'b1;
        repeat (8) tick();
        check_burst("clock_gate", 0, 4);
    endtask

`ifdef FIFO_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        int first;
        first = 0;
        do_reset();
        i_ready = 1'b1;
        push_words(1);
        for (int k = 1; k <= 40 && first == 0; k++) begin
            tick();
            if (o_busy === 1'b1) first = k;
        end
        total++;
        if (first < TIMEOUT || first > TIMEOUT + 2) begin
            bad++;
            $display("FAIL timeout_start got=%0d exp=%0d..%0d", first, TIMEOUT, TIMEOUT + 2);
        end
        repeat (4) tick();
        check_burst("timeout", 0, 1);
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 2) == 0) push_words(1);
            i_ready = ($urandom_range(0, 9) < 7);
            i_cg    = ($urandom_range(0, 9) != 0);
            i_flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        i_flush = 1'b0; i_cg = 1'b1; i_ready = 1'b1;
        repeat (10) tick();
        total++;
        if (acc_log.size() < 20 || outq.size() != 0) begin
            bad++;
            $display("FAIL random_progress got=acc%0d/pending%0d exp=acc>=20/pending0", acc_log.size(), outq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_partial_wait();
        test_backpressure();
        test_flush();
        test_clock_gate();
`ifdef FIFO_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
